// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the LCD test-pattern sequencer.
package lcd_pkg;

  // RGB565 colour constants, {r[4:0], g[5:0], b[4:0]}
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] WHITE = 16'hFFFF;

  // Pattern indices
  localparam logic [1:0] PAT_CHECKER  = 2'd0;
  localparam logic [1:0] PAT_SPLIT    = 2'd1;
  localparam logic [1:0] PAT_BARS     = 2'd2;
  localparam logic [1:0] PAT_GRADIENT = 2'd3;

  // Pending-advance state of the sequencer
  typedef enum logic {
    SEQ_IDLE    = 1'b0,
    SEQ_PENDING = 1'b1
  } seq_state_t;

  // Lowest enabled pattern index, 0 when nothing is enabled.
  function automatic logic [1:0] first_enabled(input logic [3:0] mask);
    first_enabled = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_enabled = 2'(i);
    end
  endfunction

  // Next enabled index after idx, wrapping 3->0. The search ends on idx
  // itself, so a single enabled pattern maps to itself; an empty mask gives 0.
  function automatic logic [1:0] next_enabled(input logic [1:0] idx, input logic [3:0] mask);
    logic [1:0] cand;
    logic       found;
    found        = 1'b0;
    next_enabled = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = idx + 2'(i);
      if (!found && mask[cand]) begin
        next_enabled = cand;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational pattern generator: pattern index and pixel coordinate to RGB565.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int CHK_BIT = 4,
  parameter int SPLIT_X = 80
) (
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  output logic [15:0] o_color
);

  localparam logic [7:0] SPLIT_L = 8'(SPLIT_X);

  // Select the colour of the requested pattern at (i_x, i_y)
  always_comb begin
    o_color = BLACK;
    case (i_idx)
      PAT_CHECKER:  o_color = (i_x[CHK_BIT] ^ i_y[CHK_BIT]) ? GREEN : BLUE;
      PAT_SPLIT:    o_color = (i_x > SPLIT_L) ? GREEN : RED;
      PAT_BARS:     o_color = {{5{i_x[4]}}, {6{i_x[5]}}, {5{i_x[6]}}};
      PAT_GRADIENT: o_color = {i_y[7:3], i_x[6:1], 5'd0};
      default:      o_color = BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer for the st7735 driver colour input.
// Frame starts are found from the driver's x/y scan; pattern changes (dwell
// expiry or manual request) are applied only in the frame-start cycle.
module lcd_pattern_sequencer
  import lcd_pkg::*;
#(
  parameter int         H_RES        = 128,
  parameter int         V_RES        = 160,
  parameter int         DWELL_FRAMES = 60,
  parameter int         CHK_BIT      = 4,
  parameter int         SPLIT_X      = 80,
  parameter logic [3:0] PAT_EN       = 4'b1111
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        advance_req,
  input  logic        hold,
  output logic [15:0] color,
  output logic [1:0]  pattern_idx,
  output logic        frame_start
);

  // advance_req/hold are sampled every cycle; advance_req is a one-cycle
  // pulse, and one not landing in a frame-start cycle is remembered
  // (non-accumulating) until the next frame start.

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
  localparam logic [1:0]  RST_IDX    = first_enabled(PAT_EN);

  if (H_RES < 1 || H_RES > 256 || V_RES < 1 || V_RES > 256 ||
      DWELL_FRAMES < 1 || DWELL_FRAMES > 65535 || CHK_BIT < 0 || CHK_BIT > 7) begin : g_bad_param
    $error("lcd_pattern_sequencer: parameter out of range");
  end

  logic [7:0]  r_prev_x;
  logic [7:0]  r_prev_y;
  logic        r_frame_start;
  logic [15:0] r_dwell;
  logic [15:0] w_dwell_nxt;
  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic [15:0] r_color;
  logic [15:0] w_color;
  logic        w_fs_det;
  logic        w_step;

  // A frame starts on the first cycle the scan sits at (0,0)
  assign w_fs_det = (x == 8'd0) && (y == 8'd0) &&
                    !((r_prev_x == 8'd0) && (r_prev_y == 8'd0));

  assign w_step = (r_state == SEQ_PENDING) || advance_req ||
                  (!hold && (r_dwell == DWELL_LAST));

  // Next-state for pattern index, dwell counter and pending flag
  always_comb begin
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    w_state_nxt = r_state;
    if (w_fs_det) begin
      if (w_step) begin
        w_idx_nxt   = next_enabled(r_idx, PAT_EN);
        w_dwell_nxt = 16'd0;
        w_state_nxt = SEQ_IDLE;
      end else if (!hold) begin
        w_dwell_nxt = r_dwell + 16'd1;
      end
    end else if (advance_req) begin
      w_state_nxt = SEQ_PENDING;
    end
  end

  // Pixel (0,0) of a new frame already uses the index chosen in that cycle
  lcd_pattern_gen #(
    .CHK_BIT (CHK_BIT),
    .SPLIT_X (SPLIT_X)
  ) u_gen (
    .i_idx   (w_idx_nxt),
    .i_x     (x),
    .i_y     (y),
    .o_color (w_color)
  );

  // State, frame-start pulse and registered colour
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prev_x      <= 8'hFF;
      r_prev_y      <= 8'hFF;
      r_frame_start <= 1'b0;
      r_dwell       <= 16'd0;
      r_state       <= SEQ_IDLE;
      r_idx         <= RST_IDX;
      r_color       <= BLACK;
    end else begin
      r_prev_x      <= x;
      r_prev_y      <= y;
      r_frame_start <= w_fs_det;
      r_dwell       <= w_dwell_nxt;
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_color       <= w_color;
    end
  end

  assign color       = r_color;
  assign pattern_idx = r_idx;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Bench for lcd_pattern_sequencer: four instances with different dwell/mask
// settings share the scan coordinates and reset; each has its own
// advance_req/hold. Instance 0 colours are checked through a scoreboard.
module tb_lcd_pattern_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [3:0]  adv;
  logic [3:0]  hold;
  logic [15:0] color [4];
  logic [1:0]  idx   [4];
  logic        fs    [4];

  int n_tests = 0;
  int n_fail  = 0;
  int fs_cnt [4] = '{0, 0, 0, 0};

  logic [15:0] exp_q[$];
  logic [1:0]  e_idx;
  logic        prev_origin;

  localparam int NPIX = 10;
  logic [7:0] px_tab [NPIX] = '{8'd0, 8'd16, 8'd0,  8'd16, 8'd80, 8'd81, 8'd50, 8'd112, 8'd127, 8'd200};
  logic [7:0] py_tab [NPIX] = '{8'd0, 8'd0,  8'd16, 8'd16, 8'd3,  8'd3,  8'd70, 8'd159, 8'd8,   8'd200};

  // inst 0: dwell 2, all patterns; inst 1: dwell 60; inst 2: dwell 1, mask 1010; inst 3: dwell 2, mask 0100
  lcd_pattern_sequencer #(.DWELL_FRAMES(2), .PAT_EN(4'b1111)) u_dut (
    .clk(clk), .nrst(nrst), .x(x), .y(y), .advance_req(adv[0]), .hold(hold[0]),
    .color(color[0]), .pattern_idx(idx[0]), .frame_start(fs[0]));
  lcd_pattern_sequencer #(.DWELL_FRAMES(60), .PAT_EN(4'b1111)) u_d60 (
    .clk(clk), .nrst(nrst), .x(x), .y(y), .advance_req(adv[1]), .hold(hold[1]),
    .color(color[1]), .pattern_idx(idx[1]), .frame_start(fs[1]));
  lcd_pattern_sequencer #(.DWELL_FRAMES(1), .PAT_EN(4'b1010)) u_alt (
    .clk(clk), .nrst(nrst), .x(x), .y(y), .advance_req(adv[2]), .hold(hold[2]),
    .color(color[2]), .pattern_idx(idx[2]), .frame_start(fs[2]));
  lcd_pattern_sequencer #(.DWELL_FRAMES(2), .PAT_EN(4'b0100)) u_one (
    .clk(clk), .nrst(nrst), .x(x), .y(y), .advance_req(adv[3]), .hold(hold[3]),
    .color(color[3]), .pattern_idx(idx[3]), .frame_start(fs[3]));

  // Frame-start pulse counter per instance
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (fs[k] === 1'b1) fs_cnt[k]++;
  end

  // Hang guard
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference colour model ----------------
  function automatic logic [15:0] model_color(input logic [1:0] p, input logic [7:0] px, input logic [7:0] py);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    case (p)
      2'd0: model_color = (px[4] != py[4]) ? 16'h07E0 : 16'h001F;
      2'd1: model_color = (px > 8'd80) ? 16'h07E0 : 16'hF800;
      2'd2: begin
        r = px[4] ? 5'h1F : 5'h00;
        g = px[5] ? 6'h3F : 6'h00;
        b = px[6] ? 5'h1F : 5'h00;
        model_color = {r, g, b};
      end
      default: model_color = {py[7:3], px[6:1], 5'b00000};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    nrst = 1'b0;
    adv  = 4'b0000;
    hold = 4'b0000;
    x    = 8'd9;
    y    = 8'd9;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    prev_origin = 1'b0;
    @(negedge clk);
  endtask

  // One pixel held for 2 clocks; colour and frame_start of instance 0 checked
  task automatic drive_pixel(input logic [7:0] px, input logic [7:0] py);
    logic [15:0] want;
    logic        origin;
    logic        fs_want;
    x = px;
    y = py;
    exp_q.push_back(model_color(e_idx, px, py));
    origin      = (px == 8'd0) && (py == 8'd0);
    fs_want     = origin && !prev_origin;
    prev_origin = origin;
    @(negedge clk);
    adv  = 4'b0000;
    want = exp_q.pop_front();
    n_tests++;
    if (color[0] !== want) begin
      n_fail++;
      $display("FAIL color at (%0d,%0d) pattern %0d: got %h expected %h", px, py, e_idx, color[0], want);
    end
    n_tests++;
    if (fs[0] !== fs_want) begin
      n_fail++;
      $display("FAIL frame_start at (%0d,%0d): got %b expected %b", px, py, fs[0], fs_want);
    end
    @(negedge clk);
  endtask

  // Short frame: pixel table scan, optional advance at (0,0) and mid-frame
  task automatic run_frame(input logic [1:0] e_main, input logic [3:0] adv_start,
                           input logic [3:0] adv_mid, input int n_mid);
    e_idx = e_main;
    adv   = adv_start;
    for (int i = 0; i < NPIX; i++) begin
      drive_pixel(px_tab[i], py_tab[i]);
      if (i == 2) begin
        for (int j = 0; j < n_mid; j++) begin
          adv = adv_mid;
          @(negedge clk);
          adv = 4'b0000;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_idx(input int inst, input logic [1:0] want, input string tag);
    n_tests++;
    if (idx[inst] !== want) begin
      n_fail++;
      $display("FAIL %s: instance %0d pattern_idx got %0d expected %0d", tag, inst, idx[inst], want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 1'b0;
    adv  = 4'b0000;
    hold = 4'b0000;
    x    = 8'd9;
    y    = 8'd9;
    @(negedge clk);
    n_tests++;
    if (color[0] !== 16'h0000) begin n_fail++; $display("FAIL reset color: got %h expected 0000", color[0]); end
    n_tests++;
    if (fs[0] !== 1'b0) begin n_fail++; $display("FAIL reset frame_start: got %b expected 0", fs[0]); end
    check_idx(0, 2'd0, "reset idx");
    check_idx(1, 2'd0, "reset idx");
    check_idx(2, 2'd1, "reset idx mask 1010");
    check_idx(3, 2'd2, "reset idx mask 0100");
    @(negedge clk);
    nrst = 1'b1;
    prev_origin = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dwell();
    int f0;
    do_reset();
    f0 = fs_cnt[0];
    for (int k = 1; k <= 8; k++) begin
      run_frame(2'((k / 2) % 4), 4'b0000, 4'b0000, 0);
      check_idx(0, 2'((k / 2) % 4), "dwell step");
    end
    n_tests++;
    if (fs_cnt[0] - f0 !== 8) begin
      n_fail++;
      $display("FAIL dwell frame count: got %0d expected 8", fs_cnt[0] - f0);
    end
  endtask

  task automatic test_origin_hold();
    int f0;
    do_reset();
    f0    = fs_cnt[0];
    e_idx = 2'd0;
    for (int k = 0; k < 6; k++) drive_pixel(8'd0, 8'd0);
    for (int i = 1; i < NPIX; i++) drive_pixel(px_tab[i], py_tab[i]);
    n_tests++;
    if (fs_cnt[0] - f0 !== 1) begin
      n_fail++;
      $display("FAIL origin hold pulses: got %0d expected 1", fs_cnt[0] - f0);
    end
  endtask

  task automatic test_advance();
    do_reset();
    run_frame(2'd0, 4'b0000, 4'b0010, 1);
    check_idx(1, 2'd0, "advance before frame start");
    run_frame(2'd1, 4'b0000, 4'b0010, 3);
    check_idx(1, 2'd1, "advance applied");
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    check_idx(1, 2'd2, "three requests one step");
    run_frame(2'd2, 4'b0000, 4'b0000, 0);
    check_idx(1, 2'd2, "no accumulated step");
  endtask

  task automatic test_hold();
    do_reset();
    hold = 4'b0001;
    for (int f = 1; f <= 100; f++) begin
      run_frame(2'd0, 4'b0000, (f == 100) ? 4'b0001 : 4'b0000, (f == 100) ? 1 : 0);
      check_idx(0, 2'd0, "hold frozen");
    end
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd1, "advance during hold");
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd1, "hold after advance");
    hold = 4'b0000;
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd1, "released dwell 1");
    run_frame(2'd2, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd2, "released dwell expiry");
  endtask

  task automatic test_mask();
    logic [1:0] alt_seq [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run_frame(2'((k / 2) % 4), 4'b0000, 4'b0000, 0);
      check_idx(2, alt_seq[k-1], "mask 1010 sequence");
      check_idx(3, 2'd2, "mask 0100 fixed");
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame(2'd0, 4'b0000, 4'b0000, 0);
    run_frame(2'd1, 4'b0001, 4'b0000, 0);
    check_idx(0, 2'd1, "coincident single step");
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd1, "pending cleared");
    run_frame(2'd2, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd2, "dwell restarted");
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame(2'd0, 4'b0000, 4'b0000, 0);
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    run_frame(2'd1, 4'b0000, 4'b0000, 0);
    e_idx = 2'd2;
    drive_pixel(8'd0, 8'd0);
    drive_pixel(8'd50, 8'd70);
    #2;
    nrst = 1'b0;
    #1;
    n_tests++;
    if (color[0] !== 16'h0000) begin n_fail++; $display("FAIL async reset color: got %h expected 0000", color[0]); end
    check_idx(0, 2'd0, "async reset idx");
    @(negedge clk);
    nrst = 1'b1;
    prev_origin = 1'b0;
    run_frame(2'd0, 4'b0000, 4'b0000, 0);
    check_idx(0, 2'd0, "first frame after reset");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_dwell();
    test_origin_hold();
    test_advance();
    test_hold();
    test_mask();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
